fir_sequencer: RTL and testbench
================================

FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter TAPS, default 8: number of coefficients per load.
REQ-002 SHALL have parameter DW, default 8: signed sample and coefficient width.
REQ-003 SHALL have parameter ACC_W, default 32: signed datapath result width.
REQ-004 SHALL have parameter DP_LATENCY, default 1 (range 1-4): cycles from an o_shift_enable high edge to a valid i_fir_data.
REQ-005 SHALL have parameter OUT_DEPTH, default 4: result FIFO entries.
REQ-006 clk  in  1  the single clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 i_load_req  in  1  pulse requesting a coefficient (re)load.
REQ-009 s_coeff_valid / s_coeff_ready  in / out  1 each  coefficient stream handshake.
REQ-010 s_coeff_data  in  DW  signed coefficient, in order h[0]..h[TAPS-1].
REQ-011 s_sample_valid / s_sample_ready  in / out  1 each  sample stream handshake.
REQ-012 s_sample_data  in  DW  signed input sample.
REQ-013 o_coeff_write_en / o_coeff_addr / o_coeff_data  out  1 / clog2(TAPS) / DW  coefficient write port to the FIR datapath.
REQ-014 o_shift_enable / o_data  out  1 / DW  sample push to the FIR datapath.
REQ-015 i_fir_data  in  ACC_W  FIR datapath output.
REQ-016 m_valid / m_ready  out / in  1 each  result stream handshake.
REQ-017 m_data  out  ACC_W  filter result.
REQ-018 o_state  out  2  current state: IDLE=0, LOAD=1, DRAIN=2, RUN=3.

Function
REQ-019 SHALL implement the FSM IDLE->LOAD on i_load_req; LOAD->RUN after the TAPS-th coefficient handshake; RUN->DRAIN on i_load_req; DRAIN->LOAD when the in-flight count is 0.
REQ-020 SHALL complete a coefficient handshake when s_coeff_valid && s_coeff_ready; s_coeff_ready SHALL equal (state==LOAD).
REQ-021 SHALL register each coefficient handshake so that o_coeff_write_en=1, o_coeff_data=data and o_coeff_addr=index are presented the following cycle; the index SHALL run 0..TAPS-1 and clear on LOAD entry.
REQ-022 SHALL drive o_coeff_write_en=0 in every cycle without a coefficient handshake on the previous edge; gaps in s_coeff_valid SHALL stall the index.
REQ-023 SHALL define credits = OUT_DEPTH - fifo_count - inflight.
REQ-024 SHALL drive s_sample_ready = (state==RUN) && (credits>0), combinationally.
REQ-025 SHALL register each sample handshake so that o_shift_enable=1 and o_data=sample are presented for exactly one cycle on the next cycle; otherwise o_shift_enable=0 and o_data holds its value.
REQ-026 SHALL track in-flight results with a DP_LATENCY-deep valid pipeline fed by o_shift_enable.
REQ-027 SHALL write i_fir_data into the FIFO on the edge where the pipeline's last stage is 1.
REQ-028 SHALL never let the FIFO overflow, which the credit rule guarantees.
REQ-029 SHALL drive m_valid = (fifo_count>0) with m_data = FIFO head; an entry SHALL pop on m_valid && m_ready.
REQ-030 SHALL handle a simultaneous push and pop in one cycle with fifo_count unchanged.
REQ-031 SHALL let the FIFO pointers wrap modulo OUT_DEPTH.
REQ-032 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-033 SHALL preserve FIFO contents and keep them drainable during DRAIN and LOAD.
REQ-034 SHALL ignore i_load_req in LOAD and DRAIN; i_load_req in RUN in the same cycle as a sample handshake SHALL accept that sample, which counts as in-flight.
REQ-035 SHALL pass data through unmodified, with no arithmetic on samples or results.

Reset
REQ-036 On rst high, SHALL immediately force state=IDLE and clear the coefficient index, valid pipeline, FIFO pointers and fifo_count.
REQ-037 On rst high, SHALL drive o_coeff_write_en=0, o_coeff_addr=0, o_coeff_data=0, o_shift_enable=0, o_data=0, m_valid=0, s_coeff_ready=0 and s_sample_ready=0.
REQ-038 Reset mid-LOAD or mid-RUN SHALL discard partial loads and in-flight results; after reset a full reload SHALL be required before RUN.

Verification
REQ-039 Reset: assert rst mid-cycle -> all outputs 0 without waiting for a clock edge; o_state=0.
REQ-040 Load: pulse i_load_req, stream 8,4,2,1,0,0,0,0 with one gap cycle after the 2nd value -> o_coeff_write_en pulses 8 times at addr 0..7 with matching data; o_state=3 afterwards.
REQ-041 Impulse, with the datapath model attached (DP_LATENCY=1): samples 1,0,0,0,0 with m_ready=1 -> m_data sequence 8,4,2,1,0.
REQ-042 Backpressure: m_ready=0 and s_sample_valid=1 continuously -> exactly 4 samples accepted, then s_sample_ready=0; raising m_ready for 1 cycle -> exactly one more sample accepted; results are in order.
REQ-043 Reload mid-run: i_load_req coincident with a sample handshake -> that sample's result still enters the FIFO; o_state passes through 2 then 1; coefficients 1..8 load; samples 10,20 -> results 10, 40.
REQ-044 Reset mid-load after 3 coefficients -> o_state=0, FIFO empty; a subsequent full load succeeds at addr 0..7.

Source files
------------

// File: rtl/fir_sequencer.sv
// fir_sequencer: control front-end for an external FIR datapath.
// It loads coefficients into the datapath and pushes samples into it. A
// credit scheme reserves result-FIFO space for every sample in flight, so
// datapath results are always collected in order and can never be dropped.
module fir_sequencer #(
  parameter int TAPS       = 8,
  parameter int DW         = 8,
  parameter int ACC_W      = 32,
  parameter int DP_LATENCY = 1,
  parameter int OUT_DEPTH  = 4,
  localparam int AW        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_req,
  input  logic             s_coeff_valid,
  output logic             s_coeff_ready,
  input  logic [DW-1:0]    s_coeff_data,
  input  logic             s_sample_valid,
  output logic             s_sample_ready,
  input  logic [DW-1:0]    s_sample_data,
  output logic             o_coeff_write_en,
  output logic [AW-1:0]    o_coeff_addr,
  output logic [DW-1:0]    o_coeff_data,
  output logic             o_shift_enable,
  output logic [DW-1:0]    o_data,
  input  logic [ACC_W-1:0] i_fir_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_data,
  output logic [1:0]       o_state
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int UW = $clog2(OUT_DEPTH + DP_LATENCY + 2) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t                state_r;
  logic [AW-1:0]         idx_r;
  logic [DP_LATENCY-1:0] pipe_r;
  logic [DP_LATENCY:0]   pipe_ext_s;
  logic [ACC_W-1:0]      mem_r [OUT_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [UW-1:0]         inflight_s;
  logic [UW-1:0]         used_s;
  logic                  coeff_hs_s;
  logic                  sample_hs_s;
  logic                  push_s;
  logic                  pop_s;

  // In-flight results: the sample being presented this cycle plus every
  // occupied stage of the latency pipeline; used slots add the FIFO fill.
  always_comb begin
    inflight_s = UW'(o_shift_enable);
    for (int i = 0; i < DP_LATENCY; i++) begin
      inflight_s = inflight_s + UW'(pipe_r[i]);
    end
    used_s = inflight_s + UW'(count_r);
  end

  assign s_coeff_ready  = (state_r == ST_LOAD);
  assign s_sample_ready = (state_r == ST_RUN) && (used_s < UW'(OUT_DEPTH));
  assign coeff_hs_s     = s_coeff_valid && s_coeff_ready;
  assign sample_hs_s    = s_sample_valid && s_sample_ready;
  assign pipe_ext_s     = {pipe_r, o_shift_enable};
  assign push_s         = pipe_r[DP_LATENCY-1];
  assign m_valid        = (count_r != '0);
  assign pop_s          = m_valid && m_ready;
  assign m_data         = m_valid ? mem_r[rd_ptr_r] : '0;
  assign o_state        = state_r;

  // Sequencer FSM with the registered coefficient write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      idx_r            <= '0;
      o_coeff_write_en <= 1'b0;
      o_coeff_addr     <= '0;
      o_coeff_data     <= '0;
    end else begin
      o_coeff_write_en <= coeff_hs_s;
      if (coeff_hs_s) begin
        o_coeff_addr <= idx_r;
        o_coeff_data <= s_coeff_data;
      end
      case (state_r)
        ST_IDLE: begin
          if (i_load_req) begin
            state_r <= ST_LOAD;
            idx_r   <= '0;
          end
        end
        ST_LOAD: begin
          if (coeff_hs_s) begin
            if (idx_r == AW'(TAPS - 1)) begin
              state_r <= ST_RUN;
              idx_r   <= '0;
            end else begin
              idx_r <= idx_r + AW'(1);
            end
          end
        end
        ST_RUN: begin
          if (i_load_req) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Wait until every accepted sample has produced its result.
          if (inflight_s == '0) begin
            state_r <= ST_LOAD;
            idx_r   <= '0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

  // Registered one-cycle sample push toward the datapath; o_data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_shift_enable <= 1'b0;
      o_data         <= '0;
    end else begin
      o_shift_enable <= sample_hs_s;
      if (sample_hs_s) begin
        o_data <= s_sample_data;
      end
    end
  end

  // Valid pipeline mirroring the datapath latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_r <= '0;
    end else begin
      pipe_r <= pipe_ext_s[DP_LATENCY-1:0];
    end
  end

  // Result FIFO storage; the credit scheme guarantees a free slot on push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_fir_data;
    end
  end

  // Result FIFO pointers (wrapping modulo depth) and fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Testbench for fir_sequencer: attaches a behavioural FIR datapath and
// checks results against a convolution scoreboard built from the
// coefficients and samples the bench itself sends.
module tb_fir_sequencer;

  localparam int TAPS  = 8;
  localparam int DW    = 8;
  localparam int ACC_W = 32;
  localparam int DPL   = 1;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_load_req = 1'b0;
  logic             s_coeff_valid = 1'b0;
  logic             s_coeff_ready;
  logic [DW-1:0]    s_coeff_data = '0;
  logic             s_sample_valid = 1'b0;
  logic             s_sample_ready;
  logic [DW-1:0]    s_sample_data = '0;
  logic             o_coeff_write_en;
  logic [2:0]       o_coeff_addr;
  logic [DW-1:0]    o_coeff_data;
  logic             o_shift_enable;
  logic [DW-1:0]    o_data;
  logic [ACC_W-1:0] i_fir_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [ACC_W-1:0] m_data;
  logic [1:0]       o_state;

  fir_sequencer #(.TAPS(TAPS), .DW(DW), .ACC_W(ACC_W), .DP_LATENCY(DPL), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_load_req(i_load_req),
    .s_coeff_valid(s_coeff_valid), .s_coeff_ready(s_coeff_ready), .s_coeff_data(s_coeff_data),
    .s_sample_valid(s_sample_valid), .s_sample_ready(s_sample_ready), .s_sample_data(s_sample_data),
    .o_coeff_write_en(o_coeff_write_en), .o_coeff_addr(o_coeff_addr), .o_coeff_data(o_coeff_data),
    .o_shift_enable(o_shift_enable), .o_data(o_data), .i_fir_data(i_fir_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Behavioural FIR datapath: coefficient RAM, sample history, one-cycle result.
  int dp_coef [TAPS] = '{default: 0};
  int dp_hist [TAPS] = '{default: 0};

  function automatic int dp_sum(int x);
    int s = dp_coef[0] * x;
    for (int k = 1; k < TAPS; k++) s += dp_coef[k] * dp_hist[k-1];
    return s;
  endfunction

  always @(posedge clk) begin
    if (o_coeff_write_en) dp_coef[o_coeff_addr] <= int'($signed(o_coeff_data));
    if (o_shift_enable) begin
      dp_hist[0] <= int'($signed(o_data));
      for (int k = 1; k < TAPS; k++) dp_hist[k] <= dp_hist[k-1];
      i_fir_data <= ACC_W'(dp_sum(int'($signed(o_data))));
    end
  end

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  int coef [TAPS] = '{default: 0};
  int load_vals [TAPS];
  int hist [$];
  int exp_q [$];
  logic [ACC_W-1:0] got_q [$];
  int wr_addr_q [$];
  int wr_data_q [$];
  int state_q [$];
  bit acc_flag;
  int acc_total = 0;
  int timeouts = 0;

  function automatic int fir_expect();
    int s = 0;
    for (int k = 0; k < hist.size(); k++) s += coef[k] * hist[k];
    return s;
  endfunction

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    @(negedge clk);
    acc_flag = 1'b0;
    if (s_sample_valid && s_sample_ready) begin
      acc_flag = 1'b1;
      acc_total++;
      hist.push_front(int'($signed(s_sample_data)));
      if (hist.size() > TAPS) void'(hist.pop_back());
      exp_q.push_back(fir_expect());
    end
    if (m_valid && m_ready) got_q.push_back(m_data);
    if (o_coeff_write_en) begin
      wr_addr_q.push_back(int'(o_coeff_addr));
      wr_data_q.push_back(int'($signed(o_coeff_data)));
    end
    state_q.push_back(int'(o_state));
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [DW-1:0] d);
    bit ok = 1'b0;
    s_sample_valid = 1'b1;
    s_sample_data  = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      cycle();
      ok = acc_flag;
    end
    if (!ok) timeouts++;
    s_sample_valid = 1'b0;
  endtask

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); timeouts = 0;
  endtask

  // Stream load_vals from LOAD state and check the write port and final state.
  task automatic load_coeffs(input bit gap);
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 0; i < TAPS; i++) begin
      s_coeff_valid = 1'b1;
      s_coeff_data  = DW'(load_vals[i]);
      cycle();
      if (gap && i == 1) begin
        s_coeff_valid = 1'b0;
        s_coeff_data  = DW'($urandom);
        cycle();
      end
    end
    s_coeff_valid = 1'b0;
    cycle(); cycle();
    checks++;
    if (wr_addr_q.size() != TAPS) begin
      failures++; $display("FAIL load_write_count: got %0d required %0d", wr_addr_q.size(), TAPS);
    end
    for (int i = 0; i < TAPS && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != load_vals[i]) begin
        failures++;
        $display("FAIL load_write[%0d]: got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, wr_addr_q[i], wr_data_q[i], i, load_vals[i]);
      end
    end
    checks++;
    if (o_state !== 2'd3) begin
      failures++; $display("FAIL load_state_run: got %0d required 3", o_state);
    end
    for (int i = 0; i < TAPS; i++) coef[i] = load_vals[i];
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (o_state !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d required 0", o_state);
    end
    checks++;
    if ({s_coeff_ready, s_sample_ready, o_coeff_write_en, o_coeff_addr, o_coeff_data,
         o_shift_enable, o_data, m_valid, m_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got cr=%b sr=%b we=%b a=%0d cd=%0d se=%b d=%0d mv=%b md=%0d required all 0",
               s_coeff_ready, s_sample_ready, o_coeff_write_en, o_coeff_addr, o_coeff_data,
               o_shift_enable, o_data, m_valid, m_data);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cycle(); cycle();
    checks++;
    if (o_state !== 2'd0) begin
      failures++; $display("FAIL reset_idle_hold: got %0d required 0", o_state);
    end
  endtask

  task automatic test_load();
    i_load_req = 1'b1;
    cycle();
    i_load_req = 1'b0;
    checks++;
    if (o_state !== 2'd1 || s_coeff_ready !== 1'b1) begin
      failures++; $display("FAIL load_enter: got state=%0d ready=%b required state=1 ready=1", o_state, s_coeff_ready);
    end
    load_vals = '{8, 4, 2, 1, 0, 0, 0, 0};
    load_coeffs(1'b1);
  endtask

  task automatic test_impulse();
    int imp [5] = '{8, 4, 2, 1, 0};
    clear_q();
    m_ready = 1'b1;
    send_sample(8'd1);
    for (int i = 0; i < 4; i++) send_sample(8'd0);
    repeat (6) cycle();
    checks++;
    if (timeouts != 0 || got_q.size() != 5) begin
      failures++; $display("FAIL impulse_count: got %0d results (%0d timeouts) required 5", got_q.size(), timeouts);
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== ACC_W'(imp[i])) begin
        failures++; $display("FAIL impulse[%0d]: got %0d required %0d", i, $signed(got_q[i]), imp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    clear_q();
    m_ready = 1'b0;
    s_sample_valid = 1'b1;
    s_sample_data = DW'($urandom);
    n0 = acc_total;
    repeat (12) begin
      cycle();
      if (acc_flag) s_sample_data = DW'($urandom);
    end
    checks++;
    if (acc_total - n0 != DEPTH || s_sample_ready !== 1'b0) begin
      failures++; $display("FAIL bp_fill: got %0d accepted ready=%b required %0d ready=0", acc_total - n0, s_sample_ready, DEPTH);
    end
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    repeat (6) begin
      cycle();
      if (acc_flag) s_sample_data = DW'($urandom);
    end
    checks++;
    if (acc_total - n0 != DEPTH + 1 || s_sample_ready !== 1'b0) begin
      failures++; $display("FAIL bp_one_more: got %0d accepted ready=%b required %0d ready=0", acc_total - n0, s_sample_ready, DEPTH + 1);
    end
    s_sample_valid = 1'b0;
    m_ready = 1'b1;
    repeat (10) cycle();
    checks++;
    if (got_q.size() != DEPTH + 1) begin
      failures++; $display("FAIL bp_result_count: got %0d required %0d", got_q.size(), DEPTH + 1);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== ACC_W'(exp_q[i])) begin
        failures++; $display("FAIL bp_order[%0d]: got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
      end
    end
  endtask

  task automatic test_reload();
    bit hs;
    bit seen_drain = 1'b0;
    m_ready = 1'b1;
    clear_q();
    for (int i = 0; i < TAPS - 1; i++) send_sample(8'd0);
    repeat (4) cycle();
    clear_q();
    m_ready = 1'b0;
    checks++;
    if (s_sample_ready !== 1'b1) begin
      failures++; $display("FAIL reload_ready: got %b required 1", s_sample_ready);
    end
    s_sample_valid = 1'b1;
    s_sample_data  = 8'd0;
    i_load_req     = 1'b1;
    state_q.delete();
    cycle();
    hs = acc_flag;
    s_sample_valid = 1'b0;
    i_load_req     = 1'b0;
    for (int n = 0; n < 10 && o_state !== 2'd1; n++) cycle();
    foreach (state_q[i]) if (state_q[i] == 2) seen_drain = 1'b1;
    checks++;
    if (!hs || !seen_drain || o_state !== 2'd1) begin
      failures++; $display("FAIL reload_states: got hs=%b drain=%b state=%0d required hs=1 drain=1 state=1", hs, seen_drain, o_state);
    end
    checks++;
    if (m_valid !== 1'b1) begin
      failures++; $display("FAIL reload_fifo_kept: got m_valid=%b required 1", m_valid);
    end
    load_vals = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_coeffs(1'b0);
    m_ready = 1'b1;
    send_sample(8'd10);
    send_sample(8'd20);
    repeat (6) cycle();
    checks++;
    if (timeouts != 0 || got_q.size() != 3) begin
      failures++; $display("FAIL reload_count: got %0d results required 3", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== ACC_W'(exp_q[0]) || got_q[1] !== 32'd10 || got_q[2] !== 32'd40) begin
        failures++;
        $display("FAIL reload_results: got %0d,%0d,%0d required %0d,10,40",
                 $signed(got_q[0]), $signed(got_q[1]), $signed(got_q[2]), exp_q[0]);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic signed [DW-1:0] v;
    clear_q();
    m_ready = 1'b0;
    send_sample(DW'($urandom));
    repeat (3) cycle();
    i_load_req = 1'b1;
    cycle();
    i_load_req = 1'b0;
    for (int n = 0; n < 10 && o_state !== 2'd1; n++) cycle();
    checks++;
    if (m_valid !== 1'b1 || o_state !== 2'd1) begin
      failures++; $display("FAIL rml_pre: got m_valid=%b state=%0d required 1 and 1", m_valid, o_state);
    end
    for (int i = 0; i < 3; i++) begin
      s_coeff_valid = 1'b1;
      s_coeff_data  = DW'($urandom);
      cycle();
    end
    s_coeff_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_state !== 2'd0 || {m_valid, s_coeff_ready, s_sample_ready, o_coeff_write_en, o_coeff_addr, o_coeff_data} !== '0) begin
      failures++;
      $display("FAIL rml_async: got state=%0d mv=%b cr=%b sr=%b we=%b a=%0d d=%0d required all 0",
               o_state, m_valid, s_coeff_ready, s_sample_ready, o_coeff_write_en, o_coeff_addr, o_coeff_data);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    cycle();
    checks++;
    if (o_state !== 2'd0 || m_valid !== 1'b0) begin
      failures++; $display("FAIL rml_after: got state=%0d m_valid=%b required 0 and 0", o_state, m_valid);
    end
    i_load_req = 1'b1;
    cycle();
    i_load_req = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      v = DW'($urandom);
      load_vals[i] = int'(v);
    end
    load_coeffs(1'b0);
  endtask

  task automatic test_random();
    clear_q();
    for (int n = 0; n < 300; n++) begin
      s_sample_valid = 1'($urandom_range(0, 1));
      s_sample_data  = DW'($urandom);
      m_ready        = 1'($urandom_range(0, 1));
      cycle();
    end
    s_sample_valid = 1'b0;
    m_ready = 1'b1;
    repeat (10) cycle();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
      failures++; $display("FAIL random_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== ACC_W'(exp_q[i])) begin
        failures++; $display("FAIL random[%0d]: got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_impulse();
    test_backpressure();
    test_reload();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
